// File: rtl/fp_mul_issuer_pkg.sv
// fp_mul_issuer_pkg: shared width, float type and fp32 constants for the issuer and its benches
package fp_mul_issuer_pkg;
  localparam int FP_W = 32;
  typedef logic [FP_W-1:0] fp32_t;
  localparam fp32_t FP_ONE   = 32'h3F80_0000;
  localparam fp32_t FP_TWO   = 32'h4000_0000;
  localparam fp32_t FP_THREE = 32'h4040_0000;
  localparam fp32_t FP_SIX   = 32'h40C0_0000;
endpackage

// File: rtl/fp_mul_issuer_fifo.sv
// fp_mul_issuer_fifo: first-word-fall-through result FIFO, head reads as zero while empty
module fp_mul_issuer_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [W-1:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  // pointers carry a wrap bit so full and empty stay distinguishable
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + (AW+1)'(push);
      rd_ptr <= rd_ptr + (AW+1)'(pop);
    end
  // storage needs no reset: the head is masked while empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/fp_mul_issuer.sv
// fp_mul_issuer: credit-controlled issue front end for fp_mul; tag ports with FP_MUL_ISSUER_TAG_EN
module fp_mul_issuer
  import fp_mul_issuer_pkg::*;
#(
  parameter int LATENCY = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp32_t            in_a,
  input  fp32_t            in_b,
  output logic             mul_en,
  output fp32_t            mul_a,
  output fp32_t            mul_b,
  input  fp32_t            mul_q,
`ifdef FP_MUL_ISSUER_TAG_EN
  input  logic [TAG_W-1:0] in_tag,
  output logic [TAG_W-1:0] out_tag,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output fp32_t            out_q
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef FP_MUL_ISSUER_TAG_EN
  localparam int DW = FP_W + TAG_W;
`else
  localparam int DW = FP_W;
`endif
  logic [CW-1:0] cnt;
  logic [LATENCY-1:0] vpipe;
  logic accept, pop, empty;
  logic [DW-1:0] fifo_din, fifo_dout;
  assign in_ready = mul_en & (cnt < CW'(FIFO_DEPTH));
  assign accept = in_valid & in_ready;
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  // operand launch, free-running core enable, valid pipe and credit count
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      mul_en <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      vpipe <= '0;
      cnt <= '0;
    end else begin
      mul_en <= 1'b1;
      mul_a <= accept ? in_a : '0;
      mul_b <= accept ? in_b : '0;
      vpipe <= (vpipe << 1) | LATENCY'(accept);
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
`ifdef FP_MUL_ISSUER_TAG_EN
  logic [LATENCY*TAG_W-1:0] tpipe;
  // tags ride alongside the valid pipe, one TAG_W slice per stage
  always_ff @(posedge clk or posedge areset)
    if (areset) tpipe <= '0;
    else tpipe <= (tpipe << TAG_W) | (LATENCY*TAG_W)'(accept ? in_tag : '0);
  assign fifo_din = {tpipe[LATENCY*TAG_W-1 -: TAG_W], mul_q};
  assign {out_tag, out_q} = fifo_dout;
`else
  assign fifo_din = mul_q;
  assign out_q = fifo_dout;
`endif
  fp_mul_issuer_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (vpipe[LATENCY-1]),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (empty)
  );
endmodule

// File: tb/tb_fp_mul_issuer.sv
// tb_fp_mul_issuer: randomized and directed checks of fp_mul_issuer against a scoreboard model
module tb_fp_mul_issuer;
  import fp_mul_issuer_pkg::*;
  localparam int LAT = 5;
  localparam int DEPTH = 4;
  localparam int TW = 4;
  logic clk = 1'b0, areset = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  fp32_t in_a = '0, in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic in_ready, mul_en, out_valid;
  fp32_t mul_a, mul_b, mul_q, out_q;
`ifdef FP_MUL_ISSUER_TAG_EN
  logic [TW-1:0] out_tag;
`endif
  always #5 clk = ~clk;
  fp_mul_issuer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .areset(areset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_q(mul_q),
`ifdef FP_MUL_ISSUER_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q)
  );
  // stand-in product: exact for the directed vectors, a sign-correct scramble otherwise
  function automatic fp32_t fake_mul(fp32_t a, fp32_t b);
    if (a == FP_TWO && b == FP_THREE) return FP_SIX;
    if (a == FP_ONE && b == FP_ONE) return FP_ONE;
    if (a == 32'hC000_0000 && b == FP_THREE) return 32'hC0C0_0000;
    if (a == '0 || b == '0) return {a[31] ^ b[31], 31'b0};
    return {a[31] ^ b[31], a[30:0] ^ {b[15:0], b[30:16]}};
  endfunction
  // core stand-in: operands launched at one edge emerge LAT-1 edges later
  fp32_t cpipe [LAT-1];
  always @(posedge clk)
    if (mul_en) begin
      cpipe[0] <= fake_mul(mul_a, mul_b);
      for (int i = 1; i < LAT-1; i++) cpipe[i] <= cpipe[i-1];
    end
  assign mul_q = cpipe[LAT-2];
  typedef struct {fp32_t q; logic [TW-1:0] tag; int t;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0, cyc = 0;
  bit en_m = 0;
  fp32_t exp_a = '0, exp_b = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic iv, input fp32_t a, input fp32_t b, input logic ordy, input logic [TW-1:0] tg);
    bit ir, ov;
    in_valid = iv; in_a = a; in_b = b; out_ready = ordy; in_tag = tg;
    #1;
    ir = en_m && sb.size() < DEPTH;
    ov = sb.size() > 0 && sb[0].t <= cyc;
    check("in_ready", 32'(in_ready), 32'(ir));
    check("out_valid", 32'(out_valid), 32'(ov));
    check("mul_en", 32'(mul_en), 32'(en_m));
    check("mul_a", mul_a, exp_a);
    check("mul_b", mul_b, exp_b);
    if (ov) begin
      check("out_q", out_q, sb[0].q);
`ifdef FP_MUL_ISSUER_TAG_EN
      check("out_tag", 32'(out_tag), 32'(sb[0].tag));
`endif
    end
    if (ordy && ov) void'(sb.pop_front());
    if (iv && ir) sb.push_back('{fake_mul(a, b), tg, cyc + 1 + LAT});
    exp_a = (iv && ir) ? a : '0;
    exp_b = (iv && ir) ? b : '0;
    @(posedge clk);
    cyc++;
    en_m = 1;
    @(negedge clk);
  endtask
  task automatic do_reset();
    areset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mul_en", 32'(mul_en), 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_q", out_q, 32'd0);
`ifdef FP_MUL_ISSUER_TAG_EN
    check("rst_out_tag", 32'(out_tag), 32'd0);
`endif
    sb.delete();
    en_m = 0; exp_a = '0; exp_b = '0;
    repeat (2) @(posedge clk);
    cyc += 2;
    @(negedge clk);
    areset = 1'b0;
  endtask
  initial begin
    int lat, n;
    #2 do_reset();
    step(0, '0, '0, 1, '0);
    step(1, FP_TWO, FP_THREE, 1, '0);
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && lat < 0) begin
        lat = i;
        check("single_q", out_q, FP_SIX);
      end
      step(0, '0, '0, 1, '0);
    end
    check("latency", 32'(lat), 32'(LAT));
    step(1, FP_ONE, FP_ONE, 1, 4'd5);
    step(1, 32'hC000_0000, FP_THREE, 1, 4'd9);
    step(1, 32'h0000_0000, 32'h40A0_0000, 1, 4'd2);
    repeat (8) step(0, '0, '0, 1, '0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) n++;
      step(1, $urandom, $urandom, 0, 4'($urandom));
    end
    check("bp_accepts", 32'(n), 32'(DEPTH));
    repeat (8) step(0, '0, '0, 1, '0);
    repeat (3) step(1, $urandom, $urandom, 0, 4'($urandom));
    repeat (6) step(0, '0, '0, 0, '0);
    step(1, $urandom, $urandom, 1, 4'($urandom));
    check("cnt3_ready", 32'(in_ready), 32'd1);
    step(1, $urandom, $urandom, 0, 4'($urandom));
    step(1, $urandom, $urandom, 0, 4'($urandom));
    repeat (10) step(0, '0, '0, 1, '0);
    step(1, $urandom, $urandom, 1, 4'd3);
    step(1, $urandom, $urandom, 1, 4'd7);
    step(0, '0, '0, 1, '0);
    do_reset();
    repeat (10) step(0, '0, '0, 1, '0);
    for (int i = 0; i < 400; i++) begin
      fp32_t ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'h7FC0_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
      step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 2) != 0, 4'($urandom));
    end
    repeat (12) step(0, '0, '0, 1, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_mul_issuer.md
# fp_mul_issuer

Initiator-side front end for the pipelined single-precision `fp_mul` core. It accepts operand pairs over a valid/ready handshake and drives the core's `a`, `b` and `en` inputs. It tracks every issued operation through the core's fixed latency and captures each `q` into a small result FIFO that is drained over a second valid/ready handshake. Because `fp_mul` has no output backpressure, a credit counter guarantees that every issued result has a FIFO slot waiting for it.

## Interface
Parameters:
- `LATENCY`, default 5: cycles from operands on `mul_a`/`mul_b` to the result on `mul_q`; must be ≥1.
- `FIFO_DEPTH`, default 4: result FIFO entries; must be a power of two and ≥2.
- `TAG_W`, default 4: tag width; used only when `FP_MUL_ISSUER_TAG_EN` is defined.

Ports:
- `clk` in 1: single clock; all state is on its rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: issuer can accept an operand pair.
- `in_a` in 32: IEEE-754 single-precision operand A.
- `in_b` in 32: IEEE-754 single-precision operand B.
- `mul_en` out 1: to `fp_mul.en`.
- `mul_a` out 32: to `fp_mul.a`.
- `mul_b` out 32: to `fp_mul.b`.
- `mul_q` in 32: from `fp_mul.q`.
- `out_valid` out 1: result at FIFO head is valid.
- `out_ready` in 1: consumer accepts the head result.
- `out_q` out 32: head result.
- `in_tag` in `TAG_W` / `out_tag` out `TAG_W`: present only with the macro.

## Operation
- An input is accepted at a rising edge where `in_valid & in_ready`. A result is popped at a rising edge where `out_valid & out_ready`.
- `mul_a`/`mul_b` registers:
  - On accept, they load `in_a`/`in_b`.
  - Otherwise they load 0. Bubbles into the core are zero operands.
- `mul_en` register:
  - Forced to 0 while `areset` is asserted.
  - Set to 1 at the first edge after `areset` deasserts, then held at 1. The core free-runs.
- Valid pipe: a `LATENCY`-bit shift register.
  - Bit 0 loads the accept strobe on the same edge that loads `mul_a`/`mul_b`.
  - The tail bit set means `mul_q` currently holds that operation's result.
  - On that edge, `mul_q` is written into the FIFO.
- Result FIFO: first-word-fall-through.
  - `out_q` is the head entry.
  - `out_valid` = FIFO not empty.
- Credit counter `cnt` covers in-flight operations plus FIFO occupancy. Width is clog2(`FIFO_DEPTH`)+1.
  - Accept only: +1.
  - Pop only: −1.
  - Accept and pop on the same edge: unchanged.
- `in_ready` = `mul_en` & (`cnt` < `FIFO_DEPTH`).
  - Depends only on registered state; there is no combinational path from `out_ready` to `in_ready`.
  - Consequence: the FIFO can never overflow, so a FIFO write never meets a full FIFO.
- Simultaneous FIFO write and pop on the same edge are both performed; occupancy is unchanged.
- Arithmetic is not inspected. NaN, infinity, zero and denormal values pass through bit-exact.
- Reset mid-operation:
  - Clears the valid pipe, FIFO pointers and `cnt`.
  - Results still in flight are discarded and never written.

## Timing
Reset values:
- `in_ready` = 0
- `mul_en` = 0
- `mul_a` = `mul_b` = 0
- `out_valid` = 0
- `out_q` = 0
- `out_tag` = 0

Cycle behaviour:
- `in_ready` first rises one edge after `areset` deasserts.
- Latency: accept at edge k → FIFO write at edge k+`LATENCY` → `out_valid` high from edge k+`LATENCY` onward, provided the FIFO was empty.
- Throughput: one operation per cycle when `out_ready` is held at 1.
- Sustained rate with a stalled consumer: `FIFO_DEPTH` accepts, then `in_ready` stays low until a pop.
- Order of results is strictly the issue order.

## Configuration
- `FP_MUL_ISSUER_TAG_EN` defined:
  - Adds the `in_tag`/`out_tag` ports.
  - The tag is captured on accept, travels with the valid pipe, is stored beside `mul_q` in the FIFO, and is presented alongside `out_q`.
- `FP_MUL_ISSUER_TAG_EN` undefined:
  - Tag ports, tag pipe and tag FIFO storage are absent.
  - Behaviour is otherwise identical.

## Structure
- `fp_mul_issuer_pkg` holds:
  - `FP_W` = 32.
  - Typedef `fp32_t`.
  - Constants for 1.0 (3F800000), 2.0 (40000000), 3.0 (40400000) and 6.0 (40C00000), shared with the benches.
- One sub-module: `fp_mul_issuer_fifo`.
  - Parameterized first-word-fall-through FIFO with width and depth parameters.
  - Interface: push, pop, data in, data out, empty.
- Valid/tag pipe and credit counter live in the top module.

## Test plan
- Single operation: 40000000 × 40400000 after reset, `out_ready`=1 → `out_q`=40C00000 with `out_valid` high exactly `LATENCY` edges after accept.
- Back-to-back:
  - Stimulus: 3F800000×3F800000, C0000000×40400000 and 00000000×40A00000 on consecutive cycles.
  - Required: results 3F800000, C0C00000 and 00000000 on consecutive cycles, in issue order.
- Backpressure:
  - Stimulus: `out_ready`=0 with `in_valid` held high.
  - Required: exactly 4 accepts, after which `in_ready`=0 with no data loss.
  - Then raise `out_ready`: 4 results in order, and `in_ready` returns one edge after the first pop.
- Simultaneous accept and pop at `cnt`=3: `cnt` stays 3 and the FIFO never overflows.
- Reset mid-operation:
  - Stimulus: assert `areset` with 2 operations in flight.
  - Required: all outputs reach their reset values immediately, and no stale result appears after release.
- With `FP_MUL_ISSUER_TAG_EN`: tags 5, 9 and 2 issued with the operations → `out_tag` 5, 9 and 2, aligned with their `out_q` values.
